// File: rtl/dff_checker_if.sv
// dff_checker_if: checker bus; master drives en/clr/dut_rst/d_in/q_in/qbar_in, slave returns err_pulse/err_sticky/err_code/err_cnt/chk_cnt/state
interface dff_checker_if #(
  parameter int ERR_W = 8,
  parameter int CHK_W = 16
);
  logic en, clr, dut_rst, d_in, q_in, qbar_in;
  logic err_pulse, err_sticky;
  logic [1:0] err_code, state;
  logic [ERR_W-1:0] err_cnt;
  logic [CHK_W-1:0] chk_cnt;
  modport master (
    output en, clr, dut_rst, d_in, q_in, qbar_in,
    input  err_pulse, err_sticky, err_code, err_cnt, chk_cnt, state
  );
  modport slave (
    input  en, clr, dut_rst, d_in, q_in, qbar_in,
    output err_pulse, err_sticky, err_code, err_cnt, chk_cnt, state
  );
endinterface

// File: rtl/dff_checker.sv
// dff_checker: compares an observed DFF (q_in/qbar_in) against a one-clock reference model; ports clk, rst (async active-low), bus (dff_checker_if.slave)
module dff_checker #(
  parameter int ERR_W       = 8,
  parameter int CHK_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic clk,
  input  logic rst,
  dff_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARM = 2'b01, CHECK = 2'b10, HALT = 2'b11} state_t;
  state_t           r_state, w_nxt;
  logic             r_exp_q, r_err_pulse, r_err_sticky;
  logic [1:0]       r_err_code, w_mis;
  logic [ERR_W-1:0] r_err_cnt;
  logic [CHK_W-1:0] r_chk_cnt;
  logic             w_cmp, w_err;
  always_comb begin
    w_cmp = (r_state == CHECK) && bus.en;
    w_mis = {bus.qbar_in != ~bus.q_in, bus.q_in != r_exp_q};
    w_err = w_cmp && |w_mis;
    w_nxt = (r_state == IDLE)  ? (bus.en ? ARM : IDLE) :
            (r_state == ARM)   ? (bus.en ? CHECK : IDLE) :
            (r_state == CHECK) ? (!bus.en ? IDLE : (w_err && STOP_ON_ERR) ? HALT : CHECK) :
                                 HALT;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_exp_q      <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_code   <= 2'b00;
      r_err_cnt    <= '0;
      r_chk_cnt    <= '0;
    end else if (bus.clr) begin
      r_state      <= IDLE;
      r_exp_q      <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_code   <= 2'b00;
      r_err_cnt    <= '0;
      r_chk_cnt    <= '0;
    end else begin
      r_state     <= w_nxt;
      r_err_pulse <= w_err;
      // model loads in ARM too, so the first CHECK compare already has a valid expectation
      if (r_state == ARM || r_state == CHECK) r_exp_q <= ~bus.dut_rst & bus.d_in;
      if (w_cmp) r_chk_cnt <= r_chk_cnt + CHK_W'(r_chk_cnt != '1);
      if (w_err) begin
        r_err_cnt    <= r_err_cnt + ERR_W'(r_err_cnt != '1);
        r_err_sticky <= 1'b1;
        if (!r_err_sticky) r_err_code <= w_mis;
      end
    end
  end
  assign bus.state      = r_state;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_sticky = r_err_sticky;
  assign bus.err_code   = r_err_code;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.chk_cnt    = r_chk_cnt;
endmodule

// File: tb/tb_dff_checker.sv
// tb_dff_checker: vector-table bench for dff_checker (default, STOP_ON_ERR=1, and narrow-counter instances)
module tb_dff_checker;
  logic clk = 1'b0, rst = 1'b0;
  logic en = 0, clr = 0, dr = 0, d = 0, fq = 0, qv = 0, tie = 0;
  logic q_m = 1'b0;
  logic w_q, w_qb;
  int n_chk = 0, n_bad = 0;
  always #20 clk = ~clk;
  always @(posedge clk) q_m <= dr ? 1'b0 : d;
  assign w_q  = fq ? qv : q_m;
  assign w_qb = tie ? w_q : ~w_q;
  dff_checker_if #(.ERR_W(8), .CHK_W(16)) ia ();
  dff_checker_if #(.ERR_W(8), .CHK_W(16)) ib ();
  dff_checker_if #(.ERR_W(2), .CHK_W(2))  ic ();
  assign {ia.en, ia.clr, ia.dut_rst, ia.d_in, ia.q_in, ia.qbar_in} = {en, clr, dr, d, w_q, w_qb};
  assign {ib.en, ib.clr, ib.dut_rst, ib.d_in, ib.q_in, ib.qbar_in} = {en, clr, dr, d, w_q, w_qb};
  assign {ic.en, ic.clr, ic.dut_rst, ic.d_in, ic.q_in, ic.qbar_in} = {en, clr, dr, d, w_q, w_qb};
  dff_checker #(.ERR_W(8), .CHK_W(16), .STOP_ON_ERR(1'b0)) u_a (.clk(clk), .rst(rst), .bus(ia));
  dff_checker #(.ERR_W(8), .CHK_W(16), .STOP_ON_ERR(1'b1)) u_b (.clk(clk), .rst(rst), .bus(ib));
  dff_checker #(.ERR_W(2), .CHK_W(2),  .STOP_ON_ERR(1'b0)) u_c (.clk(clk), .rst(rst), .bus(ic));
  typedef struct {
    logic en, clr, dr, d, fq, qv, tie;
    logic pulse, sticky;
    logic [1:0] code;
    int ecnt, ccnt;
    logic [1:0] st, bst;
    int bcc, becnt;
  } vec_t;
  vec_t tv[24];
  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_a_zero(input int idx);
    check("a_pulse", idx, 32'(ia.err_pulse), 0);
    check("a_sticky", idx, 32'(ia.err_sticky), 0);
    check("a_code", idx, 32'(ia.err_code), 0);
    check("a_ecnt", idx, 32'(ia.err_cnt), 0);
    check("a_ccnt", idx, 32'(ia.chk_cnt), 0);
    check("a_state", idx, 32'(ia.state), 0);
  endtask
  initial begin
    tv[0]  = '{1,0,1,0,0,0,0, 0,0,2'd0,0,0,2'd1, 2'd1,0,0};
    tv[1]  = '{1,0,1,1,0,0,0, 0,0,2'd0,0,0,2'd2, 2'd2,0,0};
    tv[2]  = '{1,0,0,0,0,0,0, 0,0,2'd0,0,1,2'd2, 2'd2,1,0};
    tv[3]  = '{1,0,0,1,0,0,0, 0,0,2'd0,0,2,2'd2, 2'd2,2,0};
    tv[4]  = '{1,0,0,1,0,0,0, 0,0,2'd0,0,3,2'd2, 2'd2,3,0};
    tv[5]  = '{0,0,0,1,0,0,0, 0,0,2'd0,0,3,2'd0, 2'd0,3,0};
    tv[6]  = '{1,0,0,1,1,0,0, 0,0,2'd0,0,3,2'd1, 2'd1,3,0};
    tv[7]  = '{1,0,0,1,1,0,0, 0,0,2'd0,0,3,2'd2, 2'd2,3,0};
    tv[8]  = '{1,0,0,1,1,0,0, 1,1,2'd1,1,4,2'd2, 2'd3,4,1};
    tv[9]  = '{1,0,0,1,1,0,0, 1,1,2'd1,2,5,2'd2, 2'd3,4,1};
    tv[10] = '{1,0,0,1,1,0,0, 1,1,2'd1,3,6,2'd2, 2'd3,4,1};
    tv[11] = '{1,0,0,1,1,0,0, 1,1,2'd1,4,7,2'd2, 2'd3,4,1};
    tv[12] = '{0,0,0,1,0,0,0, 0,1,2'd1,4,7,2'd0, 2'd3,4,1};
    tv[13] = '{0,1,0,1,0,0,0, 0,0,2'd0,0,0,2'd0, 2'd0,0,0};
    tv[14] = '{1,0,0,1,0,0,1, 0,0,2'd0,0,0,2'd1, 2'd1,0,0};
    tv[15] = '{1,0,0,1,0,0,1, 0,0,2'd0,0,0,2'd2, 2'd2,0,0};
    tv[16] = '{1,0,0,1,0,0,1, 1,1,2'd2,1,1,2'd2, 2'd3,1,1};
    tv[17] = '{1,0,0,1,1,0,1, 1,1,2'd2,2,2,2'd2, 2'd3,1,1};
    tv[18] = '{1,1,0,1,1,0,1, 0,0,2'd0,0,0,2'd0, 2'd0,0,0};
    tv[19] = '{1,0,0,1,1,0,1, 0,0,2'd0,0,0,2'd1, 2'd1,0,0};
    tv[20] = '{1,0,0,1,1,0,1, 0,0,2'd0,0,0,2'd2, 2'd2,0,0};
    tv[21] = '{1,0,0,1,1,0,1, 1,1,2'd3,1,1,2'd2, 2'd3,1,1};
    tv[22] = '{1,0,0,1,0,0,0, 0,1,2'd3,1,2,2'd2, 2'd3,1,1};
    tv[23] = '{0,0,0,1,0,0,0, 0,1,2'd3,1,2,2'd0, 2'd3,1,1};
    #30;
    check_a_zero(-1);
    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      {en, clr, dr, d, fq, qv, tie} = {tv[i].en, tv[i].clr, tv[i].dr, tv[i].d, tv[i].fq, tv[i].qv, tv[i].tie};
      step();
      check("pulse", i, 32'(ia.err_pulse), 32'(tv[i].pulse));
      check("sticky", i, 32'(ia.err_sticky), 32'(tv[i].sticky));
      check("code", i, 32'(ia.err_code), 32'(tv[i].code));
      check("err_cnt", i, 32'(ia.err_cnt), tv[i].ecnt);
      check("chk_cnt", i, 32'(ia.chk_cnt), tv[i].ccnt);
      check("state", i, 32'(ia.state), 32'(tv[i].st));
      check("stop_state", i, 32'(ib.state), 32'(tv[i].bst));
      check("stop_chk_cnt", i, 32'(ib.chk_cnt), tv[i].bcc);
      check("stop_err_cnt", i, 32'(ib.err_cnt), tv[i].becnt);
    end
    {en, clr, dr, d, fq, qv, tie} = 7'b0100000;
    step();
    check("sat_clr_ecnt", 0, 32'(ic.err_cnt), 0);
    {en, clr, dr, d, fq, qv, tie} = 7'b1001100;
    step();
    step();
    check("sat_state", 0, 32'(ic.state), 2);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("sat_pulse", k, 32'(ic.err_pulse), 1);
      check("sat_err_cnt", k, 32'(ic.err_cnt), (k > 3) ? 3 : k);
      check("sat_chk_cnt", k, 32'(ic.chk_cnt), (k > 3) ? 3 : k);
    end
    #10;
    rst = 1'b0;
    #1;
    check_a_zero(100);
    check("async_c_pulse", 100, 32'(ic.err_pulse), 0);
    check("async_c_ecnt", 100, 32'(ic.err_cnt), 0);
    {en, fq} = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rel_state", 101, 32'(ia.state), 0);
    en = 1'b1;
    step();
    check("reen_state", 102, 32'(ia.state), 1);
    check("reen_ccnt", 102, 32'(ia.chk_cnt), 0);
    step();
    check("reen_state", 103, 32'(ia.state), 2);
    check("reen_ccnt", 103, 32'(ia.chk_cnt), 0);
    step();
    check("reen_ccnt", 104, 32'(ia.chk_cnt), 1);
    check("reen_pulse", 104, 32'(ia.err_pulse), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
